// File: rtl/edge_frame_display_pkg.sv
// -----------------------------------------------------------------------------
// edge_frame_display_pkg
// Shared constants for the edge-frame display path: RGB565 colours, LCD screen
// geometry and the encoding of the bitmap writer state machine.
// -----------------------------------------------------------------------------
package edge_frame_display_pkg;

   // RGB565 colours
   localparam logic [15:0] RGB_BLACK = 16'h0000;
   localparam logic [15:0] RGB_WHITE = 16'hFFFF;
   localparam logic [15:0] RGB_BLUE  = 16'h001F;

   // LCD geometry
   localparam int H_SCREEN = 800;
   localparam int V_SCREEN = 480;

   // Bitmap writer states
   localparam logic [1:0] WR_IDLE = 2'd0;  // waiting for a camera frame start
   localparam logic [1:0] WR_FILL = 2'd1;  // capturing edge pixels
   localparam logic [1:0] WR_HOLD = 2'd2;  // frame complete, waiting for swap

endpackage

// File: rtl/edge_bitmap_ram.sv
// -----------------------------------------------------------------------------
// edge_bitmap_ram
// Two-bank, 1-bit wide simple dual-port bitmap store. The bank select is the
// most significant address index, so each bank holds DEPTH entries.
// Ports:
//   clk             system clock
//   we              write enable
//   wr_bank/wr_addr write location, wr_data the edge bit to store
//   rd_bank/rd_addr read location, rd_data valid one cycle later
// -----------------------------------------------------------------------------
module edge_bitmap_ram #(
   parameter int DEPTH = 24964,
   parameter int AW    = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  logic          wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_data
);

   logic mem [2][DEPTH];

   // NOTE: the storage array and its read register have no reset so they map
   // onto block RAM; stale contents are hidden downstream until a frame is shown.
   always_ff @(posedge clk) begin
      if (we) mem[wr_bank][wr_addr] <= wr_data;
      rd_data <= mem[rd_bank][rd_addr];
   end

endmodule

// File: rtl/edge_frame_display.sv
// -----------------------------------------------------------------------------
// edge_frame_display
// Captures the 1-bit Sobel edge stream into a double-buffered bitmap and
// replays it to the LCD pipeline as an RGB565 window. Banks swap only at the
// LCD frame start, so a displayed frame never tears.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   cam_sof          camera frame start pulse
//   edge_in          edge pixel (1 = edge), qualified by edge_valid
//   disp_sof         LCD frame start pulse (swap point)
//   pix_x, pix_y     current LCD pixel coordinate
//   pix_data         RGB565 pixel, two cycles after pix_x/pix_y
//   frame_ready      a complete frame waits for the swap
//   overrun          one-cycle pulse for each pixel dropped while waiting
// -----------------------------------------------------------------------------
module edge_frame_display
   import edge_frame_display_pkg::*;
#(
   parameter int          EDGE_W   = 158,
   parameter int          EDGE_H   = 158,
   parameter int          H_START  = 321,
   parameter int          V_START  = 161,
   parameter logic [15:0] FG_COLOR = RGB_WHITE,
   parameter logic [15:0] WIN_BG   = RGB_BLACK,
   parameter logic [15:0] SCR_BG   = RGB_BLUE
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cam_sof,
   input  logic        edge_in,
   input  logic        edge_valid,
   input  logic        disp_sof,
   input  logic [9:0]  pix_x,
   input  logic [9:0]  pix_y,
   output logic [15:0] pix_data,
   output logic        frame_ready,
   output logic        overrun
);

   localparam int          DEPTH     = EDGE_W * EDGE_H;
   localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);

   // ---------------------------------------------------------------- writer
   logic [1:0]  wr_state;
   logic [14:0] wr_addr;
   logic        wr_bank;
   logic        rd_bank;
   logic        shown;
   logic        ram_we;
   logic [14:0] ram_waddr;

   // cam_sof restarts the frame at address 0, and a pixel arriving in the same
   // cycle lands there; nothing is written while a finished frame is held.
   // NOTE: every output of this block gets a default first so no latch forms.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      if (wr_state != WR_HOLD && edge_valid) begin
         if (cam_sof) begin
            ram_we    = 1'b1;
            ram_waddr = '0;
         end else if (wr_state == WR_FILL) begin
            ram_we = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_state    <= WR_IDLE;
         wr_addr     <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b1;
         shown       <= 1'b0;
         frame_ready <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         overrun <= 1'b0;
         case (wr_state)
            WR_IDLE, WR_FILL: begin
               if (cam_sof) begin
                  wr_state <= WR_FILL;
                  wr_addr  <= edge_valid ? 15'd1 : 15'd0;
               end else if (wr_state == WR_FILL && edge_valid) begin
                  if (wr_addr == LAST_ADDR) begin
                     wr_addr     <= '0;
                     wr_state    <= WR_HOLD;
                     frame_ready <= 1'b1;
                  end else begin
                     wr_addr <= wr_addr + 15'd1;
                  end
               end
            end
            WR_HOLD: begin
               overrun <= edge_valid;
               // Swap only here: the reader changes bank exactly at the LCD
               // frame start, never mid-frame.
               if (disp_sof) begin
                  rd_bank     <= wr_bank;
                  wr_bank     <= ~wr_bank;
                  shown       <= 1'b1;
                  frame_ready <= 1'b0;
                  wr_state    <= WR_IDLE;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- reader
   logic [9:0]  dx;
   logic [9:0]  dy;
   logic        in_win_c;
   logic [14:0] rd_addr_c;
   logic        in_win_s1;
   logic        in_win_s2;
   logic [14:0] rd_addr_s1;
   logic        rd_bank_s1;
   logic        ram_bit;

   // Offsets wrap outside the window; the resulting address is never used
   // because in_win masks it.
   assign dx        = pix_x - 10'(H_START);
   assign dy        = pix_y - 10'(V_START);
   assign rd_addr_c = 15'(dy) * 15'(EDGE_W) + 15'(dx);
   assign in_win_c  = (pix_x >= 10'(H_START)) && (pix_x <= 10'(H_START + EDGE_W - 1)) &&
                      (pix_y >= 10'(V_START)) && (pix_y <= 10'(V_START + EDGE_H - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_win_s1  <= 1'b0;
         in_win_s2  <= 1'b0;
         rd_addr_s1 <= '0;
         rd_bank_s1 <= 1'b1;
      end else begin
         in_win_s1  <= in_win_c;
         in_win_s2  <= in_win_s1;
         rd_addr_s1 <= rd_addr_c;
         rd_bank_s1 <= rd_bank;
      end
   end

   edge_bitmap_ram #(
      .DEPTH (DEPTH),
      .AW    (15)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_bank (wr_bank),
      .wr_addr (ram_waddr),
      .wr_data (edge_in),
      .rd_bank (rd_bank_s1),
      .rd_addr (rd_addr_s1),
      .rd_data (ram_bit)
   );

   // Until the first swap the window is blank, hiding uninitialised RAM.
   assign pix_data = !in_win_s2 ? SCR_BG :
                     !shown     ? WIN_BG :
                     ram_bit    ? FG_COLOR : WIN_BG;

endmodule
